// File: rtl/switch_conditioner.sv
// Debounces the stopwatch pause and clear switches and derives registered level,
// rising-edge pulse and (optionally) toggle-style pause commands.
module switch_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 21,
    parameter int unsigned TOGGLE_MODE     = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic pause_raw,
    input  logic clear_raw,
    output logic pause,
    output logic clear,
    output logic pause_rise,
    output logic clear_rise
);

    localparam int unsigned ChPause = 0;
    localparam int unsigned ChClear = 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       raw;
    logic [1:0]       s1_q, s1_d;
    logic [1:0]       s2_q, s2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic             toggle_q, toggle_d;

    assign raw = {clear_raw, pause_raw};

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        deb_d = deb_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            // Any cycle where the synchronized input agrees with deb restarts the count.
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end

        // Pulses are computed from next-state so they line up with deb first reading 1.
        rise_d = deb_d & ~deb_q;

        toggle_d = toggle_q;
        if (deb_d[ChClear]) begin
            toggle_d = 1'b0;
        end else if (rise_d[ChPause]) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            deb_q    <= '0;
            rise_q   <= '0;
            toggle_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            deb_q    <= deb_d;
            rise_q   <= rise_d;
            toggle_q <= toggle_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign pause      = (TOGGLE_MODE != 0) ? toggle_q : deb_q[ChPause];
    assign clear      = deb_q[ChClear];
    assign pause_rise = rise_q[ChPause];
    assign clear_rise = rise_q[ChClear];

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench: level-mode and toggle-mode conditioners share stimulus, DEBOUNCE_CYCLES=4.
module tb_switch_conditioner;

    localparam int unsigned Deb  = 4;
    localparam int unsigned CntW = 3;

    logic clock = 1'b0;
    logic reset;
    logic pause_raw;
    logic clear_raw;
    logic pause0, clear0, prise0, crise0;
    logic pause1, clear1, prise1, crise1;

    int n_checks = 0;
    int n_fail   = 0;
    int rises0;
    int rises1;

    always #5 clock = ~clock;

    switch_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (CntW),
        .TOGGLE_MODE    (0)
    ) dut0 (
        .clock     (clock),
        .reset     (reset),
        .pause_raw (pause_raw),
        .clear_raw (clear_raw),
        .pause     (pause0),
        .clear     (clear0),
        .pause_rise(prise0),
        .clear_rise(crise0)
    );

    switch_conditioner #(
        .DEBOUNCE_CYCLES(Deb),
        .CNT_W          (CntW),
        .TOGGLE_MODE    (1)
    ) dut1 (
        .clock     (clock),
        .reset     (reset),
        .pause_raw (pause_raw),
        .clear_raw (clear_raw),
        .pause     (pause1),
        .clear     (clear1),
        .pause_rise(prise1),
        .clear_rise(crise1)
    );

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_pause0"}, pause0, 1'b0);
        chk({tag, "_clear0"}, clear0, 1'b0);
        chk({tag, "_prise0"}, prise0, 1'b0);
        chk({tag, "_crise0"}, crise0, 1'b0);
        chk({tag, "_pause1"}, pause1, 1'b0);
        chk({tag, "_prise1"}, prise1, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        pause_raw = 1'b0;
        clear_raw = 1'b0;
        tick(3);
        chk_all_low("reset");
        reset = 1'b0;
        tick(2);
        chk_all_low("idle");

        // Clean press: first sampled at edge 0, deb/pulse after edge 5.
        pause_raw = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            chk("press_wait_level", pause0, 1'b0);
            chk("press_wait_rise", prise0, 1'b0);
        end
        tick(1);
        chk("press_level", pause0, 1'b1);
        chk("press_rise", prise0, 1'b1);
        chk("press_toggle", pause1, 1'b1);
        chk("press_toggle_rise", prise1, 1'b1);
        tick(1);
        chk("press_rise_end", prise0, 1'b0);
        chk("press_level_hold", pause0, 1'b1);
        chk("press_toggle_rise_end", prise1, 1'b0);

        // Release: level falls after Deb+2 edges, no pulses, toggle keeps its state.
        pause_raw = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            chk("release_wait_level", pause0, 1'b1);
            chk("release_no_rise0", prise0, 1'b0);
            chk("release_no_rise1", prise1, 1'b0);
        end
        tick(1);
        chk("release_level", pause0, 1'b0);
        chk("release_no_rise_final", prise0, 1'b0);
        chk("release_toggle_hold", pause1, 1'b1);

        // Bounce on clear: 3 high, 1 low, 3 high, then low; never accepted.
        for (int e = 0; e < 15; e++) begin
            clear_raw = (e < 3) || (e >= 4 && e < 7);
            tick(1);
            chk("bounce_clear0", clear0, 1'b0);
            chk("bounce_crise0", crise0, 1'b0);
            chk("bounce_clear1", clear1, 1'b0);
            chk("bounce_pause1", pause1, 1'b1);
        end

        // Toggle mode: three presses of 10 clocks with 10-clock gaps.
        reset = 1'b1;
        tick(2);
        chk("toggle_reset", pause1, 1'b0);
        reset = 1'b0;
        tick(1);
        rises0 = 0;
        rises1 = 0;
        for (int p = 0; p < 3; p++) begin
            pause_raw = 1'b1;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                rises0 += int'(prise0);
                rises1 += int'(prise1);
            end
            chk("toggle_after_press", pause1, (p % 2) == 0);
            chk("level_after_press", pause0, 1'b1);
            pause_raw = 1'b0;
            for (int c = 0; c < 10; c++) begin
                tick(1);
                rises0 += int'(prise0);
                rises1 += int'(prise1);
            end
            chk("toggle_after_gap", pause1, (p % 2) == 0);
            chk("level_after_gap", pause0, 1'b0);
        end
        chk_int("toggle_rise_count1", rises1, 3);
        chk_int("toggle_rise_count0", rises0, 3);

        // Clear priority: pause=1, both pressed together.
        pause_raw = 1'b1;
        clear_raw = 1'b1;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            chk("prio_wait_pause1", pause1, 1'b1);
            chk("prio_wait_clear1", clear1, 1'b0);
        end
        tick(1);
        chk("prio_clear1", clear1, 1'b1);
        chk("prio_pause1", pause1, 1'b0);
        chk("prio_prise1", prise1, 1'b1);
        chk("prio_crise1", crise1, 1'b1);
        chk("prio_pause0", pause0, 1'b1);
        chk("prio_crise0", crise0, 1'b1);
        for (int e = 0; e < 4; e++) begin
            tick(1);
            chk("prio_hold_pause1", pause1, 1'b0);
            chk("prio_hold_clear1", clear1, 1'b1);
            chk("prio_hold_crise1", crise1, 1'b0);
        end
        pause_raw = 1'b0;
        clear_raw = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            chk("prio_rel_wait_clear0", clear0, 1'b1);
            chk("prio_rel_wait_pause1", pause1, 1'b0);
        end
        tick(1);
        chk("prio_rel_clear0", clear0, 1'b0);
        chk("prio_rel_pause0", pause0, 1'b0);
        chk("prio_rel_pause1", pause1, 1'b0);
        chk("prio_rel_crise0", crise0, 1'b0);
        tick(2);

        // Reset mid-count: two counted clocks, then reset; re-debounce from zero.
        pause_raw = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        chk_all_low("midreset");
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("midreset_wait_pause0", pause0, 1'b0);
            chk("midreset_wait_prise0", prise0, 1'b0);
        end
        tick(1);
        chk("midreset_pause0", pause0, 1'b1);
        chk("midreset_prise0", prise0, 1'b1);
        chk("midreset_pause1", pause1, 1'b1);
        chk("midreset_prise1", prise1, 1'b1);
        tick(1);
        chk("midreset_prise0_end", prise0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
